// File: rtl/conv10_mac_bias_array_if.sv
// Bus bundle for the conv10 pointwise MAC lane array.
// The master drives the pixel/kernel stream and control strobes; the slave
// (the MAC array) returns raw accumulators and the requantized outputs.
interface conv10_mac_bias_array_if #(
    parameter int LANES = 8,
    parameter int WIDTH = 16
);
    logic                       layer_en;
    logic                       clr;
    logic                       layer_sel;
    logic [WIDTH-1:0]           pix;
    logic [LANES*WIDTH-1:0]     ker;
    logic [LANES*2*WIDTH-1:0]   acc_out;
    logic [LANES*WIDTH-1:0]     ofm;
    logic                       ofm_valid;

    modport master (
        output layer_en, clr, layer_sel, pix, ker,
        input  acc_out, ofm, ofm_valid
    );

    modport slave (
        input  layer_en, clr, layer_sel, pix, ker,
        output acc_out, ofm, ofm_valid
    );
endinterface

// File: rtl/conv10_mac_bias_array.sv
// conv10_mac_bias_array: parallel signed MAC lanes for conv10 1x1 layers.
// Every lane multiplies the shared pixel by its own kernel weight and
// accumulates into a wrapping 32-bit Q2.30 accumulator. A clr pulse closes
// the pixel: the pre-update accumulator plus the selected per-lane bias is
// requantized to Q1.15 and registered, and the accumulator restarts.
// Optional feature macro: MAC_SATURATE_EN (saturate Q1.15 output when the
// Q2.30 sum does not fit; default build wraps by plain bit selection).
module conv10_mac_bias_array #(
    parameter int LANES = 8,
    parameter int WIDTH = 16,
    parameter logic [LANES*2*WIDTH-1:0] BIAS_0 = '0,
    parameter logic [LANES*2*WIDTH-1:0] BIAS_1 = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    conv10_mac_bias_array_if.slave  bus
);
    localparam int AW = 2 * WIDTH;

    logic [LANES*AW-1:0]    acc_flat;
    logic [LANES*WIDTH-1:0] ofm_flat;
    logic                   ofm_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [WIDTH-1:0] ker_lane;
            logic signed [AW-1:0]    prod;
            logic signed [AW-1:0]    bias;
            logic signed [AW-1:0]    sum;
            logic signed [AW-1:0]    acc_reg;
            logic signed [AW-1:0]    acc_next;
            logic [WIDTH-1:0]        ofm_reg;
            logic [WIDTH-1:0]        ofm_next;
            logic                    lane_unused;

            assign ker_lane = bus.ker[gi*WIDTH +: WIDTH];
            assign prod     = $signed(bus.pix) * ker_lane;
            assign bias     = bus.layer_sel ? BIAS_1[gi*AW +: AW]
                                            : BIAS_0[gi*AW +: AW];
            // Capture sum uses the accumulator before this cycle's update.
            assign sum      = acc_reg + bias;

            // Guard bit and fraction tail are intentionally discarded.
            assign lane_unused = &{1'b0, sum[AW-2], sum[WIDTH-2:0]};

            // Accumulator next value: clr restarts the pixel, enable adds.
            always_comb begin
                acc_next = acc_reg;
                if (bus.clr) begin
                    acc_next = bus.layer_en ? prod : '0;
                end else if (bus.layer_en) begin
                    acc_next = acc_reg + prod;
                end
            end

            // Q2.30 -> Q1.15: keep sign, drop the guard bit and low fraction.
            always_comb begin
                ofm_next = {sum[AW-1], sum[AW-3 -: WIDTH-1]};
`ifdef MAC_SATURATE_EN
                if (sum[AW-1] != sum[AW-2]) begin
                    ofm_next = sum[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            // Lane state: accumulator always updates, ofm only on clr.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg <= '0;
                    ofm_reg <= '0;
                end else begin
                    acc_reg <= acc_next;
                    if (bus.clr) begin
                        ofm_reg <= ofm_next;
                    end
                end
            end

            assign acc_flat[gi*AW +: AW]       = acc_reg;
            assign ofm_flat[gi*WIDTH +: WIDTH] = ofm_reg;
        end
    endgenerate

    // Output strobe follows every capture by one cycle; reset suppresses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofm_valid_reg <= 1'b0;
        end else begin
            ofm_valid_reg <= bus.clr;
        end
    end

    assign bus.acc_out   = acc_flat;
    assign bus.ofm       = ofm_flat;
    assign bus.ofm_valid = ofm_valid_reg;
endmodule

// File: tb/tb_conv10_mac_bias_array.sv
// Self-checking bench for conv10_mac_bias_array: directed scenarios from the
// layer usage plus randomized traffic, all compared with an arithmetic model.
module tb_conv10_mac_bias_array;
    localparam int LANES = 8;
    localparam int WIDTH = 16;

    function automatic logic [LANES*32-1:0] mk_bias1();
        logic [LANES*32-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            v[i*32 +: 32] = 32'h0800_0000 + 32'(i) * 32'h0001_8000;
        end
        return v;
    endfunction

    localparam logic [LANES*32-1:0] B0 = '0;
    localparam logic [LANES*32-1:0] B1 = mk_bias1();

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    conv10_mac_bias_array_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    conv10_mac_bias_array #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .BIAS_0(B0),
        .BIAS_1(B1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic signed [31:0] m_acc [LANES];
    logic [15:0]        m_ofm [LANES];
    logic               m_valid;

    // Q2.30 -> Q1.15 by arithmetic: floor-divide by 2^15, then fold into range.
    function automatic logic [15:0] requant(input logic signed [31:0] s);
        int q;
        int low;
        int r;
        q = int'(s) >>> 15;
`ifdef MAC_SATURATE_EN
        if (q > 32767) return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        r = q;
`else
        low = q & 32'h7FFF;
        r = (s < 0) ? low - 32768 : low;
`endif
        return r[15:0];
    endfunction

    function automatic logic [LANES*32-1:0] exp_acc();
        logic [LANES*32-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*32 +: 32] = m_acc[i];
        return v;
    endfunction

    function automatic logic [LANES*16-1:0] exp_ofm();
        logic [LANES*16-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*16 +: 16] = m_ofm[i];
        return v;
    endfunction

    function automatic logic [LANES*16-1:0] rand_ker();
        logic [LANES*16-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    function automatic logic [LANES*16-1:0] same_ker(input logic [15:0] k);
        logic [LANES*16-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*16 +: 16] = k;
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1 time unit later.
    task automatic cycle(input logic r, input logic en, input logic c,
                         input logic sel, input logic [15:0] p,
                         input logic [LANES*16-1:0] k);
        logic signed [31:0] prod;
        logic signed [31:0] bias;
        rst           = r;
        bus.layer_en  = en;
        bus.clr       = c;
        bus.layer_sel = sel;
        bus.pix       = p;
        bus.ker       = k;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < LANES; i++) begin
                m_acc[i] = '0;
                m_ofm[i] = '0;
            end
            m_valid = 1'b0;
        end else begin
            m_valid = c;
            for (int i = 0; i < LANES; i++) begin
                prod = $signed(p) * $signed(k[i*16 +: 16]);
                bias = sel ? B1[i*32 +: 32] : B0[i*32 +: 32];
                if (c) begin
                    m_ofm[i] = requant(m_acc[i] + bias);
                    m_acc[i] = en ? prod : 32'sd0;
                end else if (en) begin
                    m_acc[i] = m_acc[i] + prod;
                end
            end
        end
        #1;
        if (c && !r) $display("[TB] capture sel=%0d ofm=%h", sel, exp_ofm());
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom), rand_ker());
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), rand_ker());
        n_tests++;
        if (bus.acc_out !== '0) begin
            n_fail++; $display("FAIL reset_acc got %h want 0", bus.acc_out);
        end
        n_tests++;
        if (bus.ofm !== '0) begin
            n_fail++; $display("FAIL reset_ofm got %h want 0", bus.ofm);
        end
        n_tests++;
        if (bus.ofm_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", bus.ofm_valid);
        end
    endtask

    // Three terms of 0x4000*0x4000 then capture with the chosen bank.
    task automatic test_basic(input logic sel, input logic [15:0] want0);
        logic [LANES*16-1:0] k;
        k = same_ker(16'h4000);
        cycle(1'b0, 1'b1, 1'b1, sel, 16'h4000, k);
        cycle(1'b0, 1'b1, 1'b0, sel, 16'h4000, k);
        cycle(1'b0, 1'b1, 1'b0, sel, 16'h4000, k);
        n_tests++;
        if (bus.acc_out[31:0] !== 32'h3000_0000 || bus.acc_out !== exp_acc()) begin
            n_fail++; $display("FAIL basic_acc sel=%0d got %h want %h", sel, bus.acc_out, exp_acc());
        end
        cycle(1'b0, 1'b0, 1'b1, sel, 16'h4000, k);
        n_tests++;
        if (bus.ofm[15:0] !== want0 || bus.ofm !== exp_ofm()) begin
            n_fail++; $display("FAIL basic_ofm sel=%0d got %h want %h", sel, bus.ofm, exp_ofm());
        end
        n_tests++;
        if (bus.ofm_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_valid got %b want 1", bus.ofm_valid);
        end
        n_tests++;
        if (bus.acc_out !== '0) begin
            n_fail++; $display("FAIL clr_noen_acc got %h want 0", bus.acc_out);
        end
        cycle(1'b0, 1'b0, 1'b0, sel, 16'h0, k);
        n_tests++;
        if (bus.ofm_valid !== 1'b0 || bus.ofm !== exp_ofm()) begin
            n_fail++; $display("FAIL basic_hold valid=%b ofm=%h want 0 %h", bus.ofm_valid, bus.ofm, exp_ofm());
        end
    endtask

    task automatic test_negative();
        logic [LANES*16-1:0] k;
        k = same_ker(16'h4000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'hC000, k);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'hC000, k);
        n_tests++;
        if (bus.acc_out[31:0] !== 32'hE000_0000) begin
            n_fail++; $display("FAIL neg_acc got %h want e0000000", bus.acc_out[31:0]);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, k);
        n_tests++;
        if (bus.ofm[15:0] !== 16'hC000 || bus.ofm !== exp_ofm()) begin
            n_fail++; $display("FAIL neg_ofm got %h want %h", bus.ofm, exp_ofm());
        end
    endtask

    task automatic test_overflow();
        logic [LANES*16-1:0] k;
        logic [15:0] want;
`ifdef MAC_SATURATE_EN
        want = 16'h7FFF;
`else
        want = 16'h2000;
`endif
        k = same_ker(16'h4000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, k);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, k);
        n_tests++;
        if (bus.acc_out[31:0] !== 32'h5000_0000) begin
            n_fail++; $display("FAIL ovf_acc got %h want 50000000", bus.acc_out[31:0]);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, k);
        n_tests++;
        if (bus.ofm[15:0] !== want || bus.ofm !== exp_ofm()) begin
            n_fail++; $display("FAIL ovf_ofm got %h want %h", bus.ofm, exp_ofm());
        end
    endtask

    task automatic test_freeze();
        logic [LANES*32-1:0] snap;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom), rand_ker());
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom), rand_ker());
        snap = exp_acc();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), rand_ker());
            n_tests++;
            if (bus.acc_out !== snap) begin
                n_fail++; $display("FAIL freeze_acc cyc=%0d got %h want %h", i, bus.acc_out, snap);
            end
        end
    endtask

    task automatic test_rst_mid();
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'($urandom), rand_ker());
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'($urandom), rand_ker());
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), rand_ker());
        n_tests++;
        if (bus.acc_out !== '0 || bus.ofm_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid acc=%h valid=%b want 0 0", bus.acc_out, bus.ofm_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, rand_ker());
        n_tests++;
        if (bus.ofm_valid !== 1'b0 || bus.ofm !== '0) begin
            n_fail++; $display("FAIL rstmid_after valid=%b ofm=%h want 0 0", bus.ofm_valid, bus.ofm);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'($urandom), 16'($urandom), rand_ker());
            n_tests++;
            if (bus.acc_out !== exp_acc() || bus.ofm !== exp_ofm() || bus.ofm_valid !== 1'b1) begin
                n_fail++; $display("FAIL b2b i=%0d acc=%h ofm=%h v=%b want %h %h 1", i,
                                   bus.acc_out, bus.ofm, bus.ofm_valid, exp_acc(), exp_ofm());
            end
        end
    endtask

    task automatic test_random();
        logic r, en, c;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(63) == 0);
            en = ($urandom_range(7) != 0);
            c  = ($urandom_range(7) == 0);
            cycle(r, en, c, 1'($urandom), 16'($urandom), rand_ker());
            n_tests++;
            if (bus.acc_out !== exp_acc() || bus.ofm !== exp_ofm() || bus.ofm_valid !== m_valid) begin
                n_fail++; $display("FAIL random i=%0d acc=%h ofm=%h v=%b want %h %h %b", i,
                                   bus.acc_out, bus.ofm, bus.ofm_valid, exp_acc(), exp_ofm(), m_valid);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < LANES; i++) begin
            m_acc[i] = '0;
            m_ofm[i] = '0;
        end
        m_valid       = 1'b0;
        rst           = 1'b1;
        bus.layer_en  = 1'b0;
        bus.clr       = 1'b0;
        bus.layer_sel = 1'b0;
        bus.pix       = '0;
        bus.ker       = '0;
        test_reset();
        test_basic(1'b0, 16'h6000);
        test_basic(1'b1, 16'h7000);
        test_negative();
        test_overflow();
        test_freeze();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
